// File: rtl/sound_cmd_latch.sv
// Main-to-sound CPU command latch: edge-detected byte FIFO with NMI on each
// accepted push, a free-running periodic IRQ and a status byte.
module sound_cmd_latch #(
  parameter int DEPTH   = 4,
  parameter int NMI_LEN = 64,
  parameter int IRQ_DIV = 200000
) (
  input  logic       CLK48M,
  input  logic       RESET,
  input  logic       SNDRQ,
  input  logic [7:0] CPUDO,
  input  logic       SCPU_CS,
  input  logic       SCPU_RD,
  input  logic       SIRQ_ACK,
  output logic [7:0] SCMD,
  output logic       SNMI,
  output logic       SIRQ,
  output logic [7:0] SSTAT
);
  localparam int AW = $clog2(DEPTH);
  localparam int NW = $clog2(NMI_LEN + 1);
  localparam int IW = $clog2(IRQ_DIV);

  logic             sndrq_q, push_pend;
  logic [7:0]       wdata_q;
  logic             acc, acc_q, pop_pend;
  logic [7:0]       mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [AW:0]      count;
  logic             ovf;
  logic [NW-1:0]    nmi_cnt;
  logic [IW-1:0]    irq_cnt;
  logic             wrap_q, sirq_q;
  logic [7:0]       scmd_q;
  logic             full, empty, do_push, do_pop;

  assign acc     = SCPU_CS & SCPU_RD;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop_pend & ~empty;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign do_push = push_pend & (~full | do_pop);

  // Edge detectors: strobes are registered, so each fires the cycle after
  // the qualifying sample; push data is captured from the first-high sample.
  always_ff @(posedge CLK48M or posedge RESET) begin
    if (RESET) begin
      sndrq_q   <= 1'b0;
      push_pend <= 1'b0;
      wdata_q   <= 8'h00;
      acc_q     <= 1'b0;
      pop_pend  <= 1'b0;
    end else begin
      sndrq_q   <= SNDRQ;
      push_pend <= SNDRQ & ~sndrq_q;
      if (SNDRQ & ~sndrq_q) wdata_q <= CPUDO;
      acc_q     <= acc;
      pop_pend  <= acc_q & ~acc;
    end
  end

  always_ff @(posedge CLK48M) begin
    if (do_push) mem[wptr] <= wdata_q;
  end

  always_ff @(posedge CLK48M or posedge RESET) begin
    if (RESET) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (do_pop)                          ovf <= 1'b0;
      else if (push_pend && full)          ovf <= 1'b1;
    end
  end

  always_ff @(posedge CLK48M or posedge RESET) begin
    if (RESET) scmd_q <= 8'hFF;
    else       scmd_q <= empty ? 8'hFF : mem[rptr];
  end

  always_ff @(posedge CLK48M or posedge RESET) begin
    if (RESET)                nmi_cnt <= '0;
    else if (do_push)         nmi_cnt <= NW'(NMI_LEN);
    else if (nmi_cnt != '0)   nmi_cnt <= nmi_cnt - NW'(1);
  end

  // SIRQ rises one cycle after the counter wraps; a coincident ack loses.
  always_ff @(posedge CLK48M or posedge RESET) begin
    if (RESET) begin
      irq_cnt <= '0;
      wrap_q  <= 1'b0;
      sirq_q  <= 1'b0;
    end else begin
      irq_cnt <= (irq_cnt == IW'(IRQ_DIV - 1)) ? '0 : irq_cnt + IW'(1);
      wrap_q  <= (irq_cnt == IW'(IRQ_DIV - 1));
      sirq_q  <= wrap_q | (sirq_q & ~SIRQ_ACK);
    end
  end

  assign SCMD  = scmd_q;
  assign SNMI  = (nmi_cnt != '0);
  assign SIRQ  = sirq_q;
  assign SSTAT = {ovf, 4'b0000, empty, full, SNMI};
endmodule

// File: tb/tb_sound_cmd_latch.sv
// Bench for sound_cmd_latch: directed scenarios plus random traffic, all
// checked against a queue-based reference model.
module tb_sound_cmd_latch;
  localparam int DEPTH   = 4;
  localparam int NMI_LEN = 64;
  localparam int IRQ_DIV = 10;

  logic       clk = 1'b0;
  logic       RESET = 1'b1;
  logic       SNDRQ = 1'b0;
  logic [7:0] CPUDO = 8'h00;
  logic       SCPU_CS = 1'b0, SCPU_RD = 1'b0, SIRQ_ACK = 1'b0;
  logic [7:0] SCMD, SSTAT;
  logic       SNMI, SIRQ;

  int n_tests = 0;
  int n_fail  = 0;

  sound_cmd_latch #(.DEPTH(DEPTH), .NMI_LEN(NMI_LEN), .IRQ_DIV(IRQ_DIV)) dut (
    .CLK48M(clk), .RESET(RESET), .SNDRQ(SNDRQ), .CPUDO(CPUDO),
    .SCPU_CS(SCPU_CS), .SCPU_RD(SCPU_RD), .SIRQ_ACK(SIRQ_ACK),
    .SCMD(SCMD), .SNMI(SNMI), .SIRQ(SIRQ), .SSTAT(SSTAT)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a byte queue, per-byte NMI timer, and IRQ timing from
  // the number of clock edges since reset release.
  logic [7:0] q[$];
  logic       m_ovf = 1'b0, m_sirq = 1'b0, m_rq = 1'b0, m_acc = 1'b0;
  logic       m_push = 1'b0, m_pop = 1'b0, pop_ok, push_ok, acc_now;
  logic [7:0] m_data = 8'h00, m_scmd = 8'hFF;
  int         m_nmi = 0, m_t = 0;

  always @(posedge clk or posedge RESET) begin
    if (RESET) begin
      q.delete();
      m_ovf = 0; m_sirq = 0; m_rq = 0; m_acc = 0; m_push = 0; m_pop = 0;
      m_scmd = 8'hFF; m_nmi = 0; m_t = 0;
    end else begin
      m_scmd  = (q.size() == 0) ? 8'hFF : q[0];
      pop_ok  = m_pop && (q.size() != 0);
      push_ok = m_push && ((q.size() < DEPTH) || pop_ok);
      if (pop_ok) begin
        void'(q.pop_front());
        m_ovf = 0;
      end
      if (m_push && !push_ok) m_ovf = 1;
      if (push_ok) q.push_back(m_data);
      if (push_ok) m_nmi = NMI_LEN;
      else if (m_nmi > 0) m_nmi--;
      m_t++;
      if (m_t > IRQ_DIV && ((m_t - 1) % IRQ_DIV) == 0) m_sirq = 1;
      else if (SIRQ_ACK) m_sirq = 0;
      m_push = SNDRQ && !m_rq;
      if (m_push) m_data = CPUDO;
      m_rq = SNDRQ;
      acc_now = SCPU_CS && SCPU_RD;
      m_pop = m_acc && !acc_now;
      m_acc = acc_now;
    end
  end

  always @(negedge clk) begin
    chk("mon_scmd", SCMD, m_scmd);
    chk("mon_snmi", 8'(SNMI), 8'(m_nmi != 0));
    chk("mon_sirq", 8'(SIRQ), 8'(m_sirq));
    chk("mon_sstat", SSTAT, {m_ovf, 4'b0000, q.size() == 0, q.size() == DEPTH, m_nmi != 0});
  end

  task automatic push_byte(input logic [7:0] b);
    @(negedge clk); #1; SNDRQ = 1'b1; CPUDO = b;
    repeat (3) @(negedge clk);
    #1; SNDRQ = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic rd();
    @(negedge clk); #1; SCPU_CS = 1'b1; SCPU_RD = 1'b1;
    repeat (3) @(negedge clk);
    #1; SCPU_CS = 1'b0; SCPU_RD = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int nh;
    logic [7:0] got [4];

    @(negedge clk);
    chk("rst_sstat", SSTAT, 8'h04);
    chk("rst_scmd", SCMD, 8'hFF);
    chk("rst_snmi", 8'(SNMI), 8'h00);
    chk("rst_sirq", 8'(SIRQ), 8'h00);

    // IRQ: rises 11 edges after release, held until acked.
    #1; RESET = 1'b0;
    repeat (10) @(posedge clk);
    #1; chk("irq_pre", 8'(SIRQ), 8'h00);
    @(posedge clk); #1; chk("irq_rise", 8'(SIRQ), 8'h01);
    repeat (3) @(posedge clk);
    #1; chk("irq_hold", 8'(SIRQ), 8'h01);
    SIRQ_ACK = 1'b1;
    @(posedge clk); #1; chk("irq_ack", 8'(SIRQ), 8'h00);
    SIRQ_ACK = 1'b0;

    // Long strobe pushes one byte; NMI pulse length.
    @(negedge clk); #1; SNDRQ = 1'b1; CPUDO = 8'h5A;
    nh = 0;
    for (int k = 1; k <= 80; k++) begin
      @(posedge clk); #1;
      if (k == 1) chk("p1_nmi_early", 8'(SNMI), 8'h00);
      if (k == 2) begin
        chk("p1_sstat", SSTAT, 8'h01);
        chk("p1_scmd_lat", SCMD, 8'hFF);
      end
      if (k == 3) chk("p1_scmd", SCMD, 8'h5A);
      if (k == 16) SNDRQ = 1'b0;
      if (SNMI) nh++;
    end
    chk("p1_nmi_len", 8'(nh), 8'(NMI_LEN));
    chk("p1_sstat_end", SSTAT, 8'h00);
    rd();
    chk("p1_one_push", SSTAT, 8'h04);

    // Overflow on fifth push, in-order drain, OVF cleared by pop.
    for (int i = 1; i <= 5; i++) push_byte(8'(i));
    repeat (70) @(negedge clk);
    chk("ovf_sstat", SSTAT, 8'h82);
    for (int i = 1; i <= 4; i++) begin
      chk("ovf_rd", SCMD, 8'(i));
      rd();
      if (i == 1) chk("ovf_clr", SSTAT & 8'h80, 8'h00);
    end
    chk("ovf_empty_scmd", SCMD, 8'hFF);
    chk("ovf_empty_sstat", SSTAT, 8'h04);

    // Full FIFO with coincident push and pop edges.
    for (int i = 0; i < 4; i++) push_byte(8'hA0 + 8'(i));
    @(negedge clk); #1; SCPU_CS = 1'b1; SCPU_RD = 1'b1;
    repeat (2) @(negedge clk);
    #1; SCPU_CS = 1'b0; SCPU_RD = 1'b0; SNDRQ = 1'b1; CPUDO = 8'hCC;
    repeat (3) @(negedge clk);
    chk("sim_flags", SSTAT & 8'h86, 8'h02);
    chk("sim_head", SCMD, 8'hA1);
    #1; SNDRQ = 1'b0;
    for (int i = 0; i < 4; i++) begin
      got[i] = SCMD;
      rd();
    end
    chk("sim_b0", got[0], 8'hA1);
    chk("sim_b1", got[1], 8'hA2);
    chk("sim_b2", got[2], 8'hA3);
    chk("sim_tail", got[3], 8'hCC);

    // Reset during NMI pulse with two bytes queued.
    push_byte(8'h11);
    push_byte(8'h22);
    @(posedge clk); #2; RESET = 1'b1;
    #1;
    chk("mid_rst_snmi", 8'(SNMI), 8'h00);
    chk("mid_rst_sstat", SSTAT, 8'h04);
    chk("mid_rst_scmd", SCMD, 8'hFF);
    @(posedge clk); #2; RESET = 1'b0;
    nh = 0;
    for (int k = 0; k < 80; k++) begin
      @(posedge clk); #1;
      if (SNMI) nh++;
    end
    chk("post_rst_nmi", 8'(nh), 8'h00);
    chk("post_rst_sstat", SSTAT, 8'h04);

    // SNDRQ held across reset: abandoned push, then exactly one after release.
    @(negedge clk); #1; SNDRQ = 1'b1; CPUDO = 8'h77;
    @(posedge clk); #2; RESET = 1'b1;
    @(posedge clk); #2; RESET = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("held_scmd", SCMD, 8'h77);
    chk("held_flags", SSTAT & 8'h86, 8'h00);
    SNDRQ = 1'b0;
    rd();
    chk("held_one", SSTAT & 8'hFE, 8'h04);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk); #1;
      if ($urandom_range(3) == 0) SNDRQ = ~SNDRQ;
      CPUDO = 8'($urandom);
      if ($urandom_range(2) == 0) SCPU_CS = 1'($urandom);
      if ($urandom_range(2) == 0) SCPU_RD = 1'($urandom);
      SIRQ_ACK = ($urandom_range(7) == 0);
      if ($urandom_range(599) == 0) RESET = 1'b1;
      else RESET = 1'b0;
    end
    @(negedge clk); #1;
    RESET = 1'b0; SNDRQ = 1'b0; SCPU_CS = 1'b0; SCPU_RD = 1'b0; SIRQ_ACK = 1'b0;
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sound_cmd_latch.md
SOUND_CMD_LATCH -- requirements
Module: sound_cmd_latch

Interface
REQ-001 Parameter DEPTH, default 4, command FIFO depth; power of two, minimum 2.
REQ-002 Parameter NMI_LEN, default 64, length of each sound-CPU NMI pulse in CLK48M cycles; minimum 1.
REQ-003 Parameter IRQ_DIV, default 200000, CLK48M cycles per periodic sound-CPU IRQ; minimum 2.
REQ-004 CLK48M  in  1  sole clock; all state SHALL change on its rising edge only.
REQ-005 RESET  in  1  asynchronous, active-high reset.
REQ-006 SNDRQ  in  1  main-CPU sound-port write strobe, level, held for several CLK48M cycles per access.
REQ-007 CPUDO  in  8  main-CPU write data, valid whenever SNDRQ is high.
REQ-008 SCPU_CS  in  1  sound-CPU read select for the command port.
REQ-009 SCPU_RD  in  1  sound-CPU read strobe, level.
REQ-010 SIRQ_ACK  in  1  sound-CPU interrupt acknowledge, level.
REQ-011 SCMD  out  8  command byte presented to the sound CPU.
REQ-012 SNMI  out  1  sound-CPU NMI request, active-high.
REQ-013 SIRQ  out  1  sound-CPU maskable interrupt request, active-high.
REQ-014 SSTAT  out  8  status byte: {OVF, 4'b0, EMPTY, FULL, NMI-busy}.

Function
REQ-015 Push: SHALL fire once, on the cycle after SNDRQ is first sampled high following a low sample, and write CPUDO from that first-high sample.
REQ-016 A single SNDRQ high period SHALL push exactly one byte, regardless of its length.
REQ-017 Read access: an access is the condition SCPU_CS & SCPU_RD.
REQ-018 Pop: SHALL fire on the first cycle the access condition is sampled low after being high, so the byte is stable for the whole access.
REQ-019 SCMD SHALL be a registered copy of the FIFO head, updated in the cycle after every push or pop.
REQ-020 SCMD SHALL be 8'hFF while the FIFO is empty.
REQ-021 Pop on an empty FIFO SHALL be ignored with no state change.
REQ-022 Push on a full FIFO without a simultaneous pop SHALL drop the byte and set sticky OVF.
REQ-023 OVF SHALL clear on the pop that follows a completed read of SSTAT, i.e. any pop while OVF=1 clears it.
REQ-024 Simultaneous push and pop SHALL both take effect and leave occupancy unchanged.
REQ-025 Simultaneous push and pop SHALL be accepted when full, with no OVF.
REQ-026 Simultaneous push and pop on empty: the push is accepted and the pop ignored.
REQ-027 Read and write pointers SHALL wrap modulo DEPTH.
REQ-028 Occupancy SHALL be held in a counter of width log2(DEPTH)+1.
REQ-029 Each accepted push SHALL (re)start an NMI counter: SNMI high for exactly NMI_LEN cycles from the push cycle +1.
REQ-030 A push during an active pulse SHALL restart the full NMI_LEN length.
REQ-031 SSTAT[0] SHALL equal SNMI.
REQ-032 IRQ counter: counts 0..IRQ_DIV-1 and wraps, width ceil(log2(IRQ_DIV)).
REQ-033 SIRQ SHALL set on the wrap cycle +1.
REQ-034 SIRQ SHALL clear on the cycle after SIRQ_ACK is sampled high.
REQ-035 If wrap and SIRQ_ACK coincide, set SHALL win.
REQ-036 The IRQ counter SHALL free-run, unaffected by the FIFO.
REQ-037 SSTAT[1] SHALL equal FULL.
REQ-038 SSTAT[2] SHALL equal EMPTY.
REQ-039 SSTAT[7] SHALL equal OVF.
REQ-040 SSTAT[6:3] SHALL equal 0.

Reset
REQ-041 RESET high SHALL immediately clear pointers, occupancy, OVF, and both counters.
REQ-042 RESET high SHALL force SNMI=0, SIRQ=0, SCMD=8'hFF, SSTAT=8'h04.
REQ-043 RESET high SHALL clear the SNDRQ and access edge-detect history to 0.
REQ-044 After RESET deasserts, an SNDRQ held high from before deassertion SHALL push once.
REQ-045 FIFO storage contents need not reset.
REQ-046 Reset asserted mid-access or mid-pulse SHALL abandon it, with no pop or push afterwards for that access.

Verification
REQ-047 SNDRQ high 16 cycles with CPUDO=8'h5A -> one push; SCMD=8'h5A two cycles after rise; SNMI high exactly 64 cycles; SSTAT=8'h01 then 8'h00.
REQ-048 Push 8'h01..8'h05 with no reads (DEPTH=4) -> 8'h05 dropped; SSTAT=8'h82; four reads return 01,02,03,04, then SCMD=8'hFF, SSTAT=8'h04, OVF cleared.
REQ-049 FIFO full, and the push edge and pop edge land on the same cycle -> occupancy stays 4, OVF=0, new byte at tail.
REQ-050 Free-run IRQ_DIV=10 with no ack -> SIRQ rises 11 cycles after reset release and stays high; SIRQ_ACK pulsed -> low the next cycle.
REQ-051 RESET asserted for one cycle during an NMI pulse with 2 bytes queued -> SNMI=0 same cycle; SSTAT=8'h04; SCMD=8'hFF; no further NMI without a new push.
